mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external SRAM-style memory bus between the instruction-fetch path and the MEM-stage load/store path, which carries the aluop/address/reg1 payload latched by the EX/MEM register. It grants one requester at a time, holds the bus transaction stable until acknowledged, and returns read data with a one-cycle done pulse. While a requester is pending it raises a stall request towards the pipeline stall controller.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, bus-wait cycles before timeout (used only with `ARB_TIMEOUT_EN`)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset (decided)
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid with if_done
- if_done  out  1  one-cycle completion pulse
- stallreq_if  out  1  combinational: if_req & ~if_done
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store
- mem_sel  in  4  byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load word, valid with mem_done
- mem_done  out  1  one-cycle completion pulse
- stallreq_mem  out  1  combinational: mem_req & ~mem_done
- bus_req  out  1  transaction valid
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/ADDR_W/DATA_W  registered transaction fields
- bus_rdata  in  DATA_W  read data, sampled with bus_ack
- bus_ack  in  1  transaction complete
- bus_err  out  1  one-cycle timeout pulse, aligned with done (always 0 without the macro)

## Operation

- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE: when mem_req is high and mem_done is low, latch the mem_* fields into the bus_* registers, assert bus_req, and go to BUSY_D. Otherwise, when if_req is high and if_done is low, latch if_addr with bus_we=0 and bus_sel=4'hF, and go to BUSY_I. Data side has fixed priority.
- A request that is high in the same cycle as its own done pulse is stale. It is not granted in that cycle.
- BUSY_x: bus_* fields stay constant. When bus_ack is sampled high, capture bus_rdata into x_rdata, pulse x_done for one cycle, drop bus_req, and return to IDLE.
- Stores: mem_rdata is updated with bus_rdata regardless. Software ignores it.
- Dropping req while BUSY has no effect. The transaction completes and done still pulses.
- bus_ack in IDLE is ignored.
- if_rdata and mem_rdata hold their value until the next completion of the same side.

## Timing

- Reset values: bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0, bus_err=0, state=IDLE.
- Latency: req seen in IDLE at edge N gives bus_req high after edge N. If ack is high in that cycle, done is high after edge N+1. Minimum is 2 cycles from req to done. Each wait cycle adds 1.
- Back-to-back: a queued request on the other side is granted in the done cycle, so bus_req drops for exactly one cycle.
- Simultaneous if_req and mem_req in IDLE: mem is granted. stallreq_if stays high throughout.
- Reset mid-transaction: after the rst edge, state is IDLE and all outputs are at reset values. A late bus_ack is ignored. No done pulse is produced.

## Configuration

- `ARB_TIMEOUT_EN` defined:
  - A 4-bit-plus wait counter clears on grant and increments each BUSY cycle without ack.
  - When the count reaches MAX_WAIT without ack, the transaction is aborted: bus_req drops, x_done and bus_err pulse together, x_rdata is loaded with 0, and state returns to IDLE.
  - An ack in the same cycle as the count reaching MAX_WAIT wins: normal completion, no error.
- Not defined: no counter exists, BUSY waits indefinitely, and bus_err is tied to 0.

## Test plan

- Reset, then fetch with if_addr=0x1C000000 and ack in the first bus cycle, bus_rdata=0x02C00000 -> bus_req for 1 cycle, if_done one cycle later, if_rdata=0x02C00000, stallreq_if low in the done cycle.
- Store with mem_addr=0x80, mem_sel=4'b0011, wdata=0xDEADBEEF, and 3 wait cycles -> bus fields stable for 4 cycles, mem_done 5 cycles after req, no if activity.
- if_req and mem_req raised together -> data transaction first, then a one-cycle gap, then the fetch. Both done pulses seen in order. stallreq_if high until its own done.
- rst asserted during BUSY_I, then ack arrives 2 cycles later -> no if_done pulse, all outputs at reset values, and the next if_req is serviced normally.
- Requester holds req through its done cycle and drops it next cycle -> exactly one bus transaction, no duplicate grant.
- With `ARB_TIMEOUT_EN` and MAX_WAIT=15, load with ack never asserted -> mem_done and bus_err pulse together, mem_rdata=0, and the arbiter accepts the next request.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one SRAM-style memory bus between the instruction-fetch path and the
// MEM-stage load/store path.  One requester is granted at a time (data side
// has fixed priority), the bus transaction is held stable until bus_ack, and
// read data is returned with a one-cycle done pulse.  While a requester waits
// it raises a stall request towards the pipeline stall controller.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined     : a wait counter aborts a transaction after MAX_WAIT cycles
//                 without ack (done + bus_err pulse, rdata loaded with 0).
//   Not defined : BUSY waits indefinitely, bus_err is tied to 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request and address (req held until done)
//   if_rdata/if_done         fetched word and completion pulse
//   stallreq_if              if_req & ~if_done
//   mem_req/we/sel/addr/wdata load/store request and payload
//   mem_rdata/mem_done       load word and completion pulse
//   stallreq_mem             mem_req & ~mem_done
//   bus_req/we/sel/addr/wdata registered bus transaction
//   bus_rdata/bus_ack        bus response
//   bus_err                  timeout pulse aligned with done
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              stallreq_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stallreq_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_e;

    // MAX_WAIT must be positive; a zero value would make the abort compare wrap.
    if (MAX_WAIT < 1) begin : g_bad_max_wait
    end

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;
`endif

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A request still high during its own done pulse is stale.
                if (mem_req && !mem_done_q) begin
                    state_d     = BUSY_D;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end else if (if_req && !if_done_q) begin
                    state_d     = BUSY_I;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'hF;
                    bus_addr_d  = if_addr;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_D, BUSY_I: begin
                // Ack wins over a simultaneous timeout.
                if (bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        mem_rdata_d = bus_rdata;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = bus_rdata;
                        if_done_d  = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // This cycle is the MAX_WAIT-th one without ack: abort.
                else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == BUSY_D) begin
                        mem_rdata_d = '0;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = state_q;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_sel      = bus_sel_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign mem_rdata    = mem_rdata_q;
    assign if_done      = if_done_q;
    assign mem_done     = mem_done_q;
    assign stallreq_if  = if_req & ~if_done_q;
    assign stallreq_mem = mem_req & ~mem_done_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_err      = bus_err_q;
`else
    assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed stimulus for mem_bus_arbiter.  A transaction-level reference model
// (who owns the bus, what was latched, what each side last received) is
// checked against every DUT output on each falling edge.  Hand-computed
// latencies and data values pin the model itself.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        stallreq_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .stallreq_if(stallreq_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stallreq_mem(stallreq_mem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder (stimulus) ----------------
    logic ack_en;
    int   wait_cfg;
    logic ack_force;
    logic ack_auto;
    int   busy_cycles;
    assign bus_ack = ack_force | ack_auto;

    initial begin
        ack_auto    = 1'b0;
        busy_cycles = 0;
    end

    // Acks after wait_cfg bus cycles of a transaction.
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            busy_cycles++;
            ack_auto = ack_en && (busy_cycles > wait_cfg);
        end else begin
            busy_cycles = 0;
            ack_auto    = 1'b0;
        end
    end

    // ---------------- transaction-level model ----------------
    int          m_owner;   // 0 = bus free, 1 = data side, 2 = fetch side
    int          m_waited;
    logic        m_req, m_we, m_if_done, m_mem_done, m_err;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
    logic        m_started = 1'b0;
    logic        mem_pend, if_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = 0; m_waited = 0;
            m_req = 0; m_we = 0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
            m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
            m_if_done = 0; m_mem_done = 0; m_err = 0;
        end else begin
            mem_pend   = mem_req && !m_mem_done;
            if_pend    = if_req && !m_if_done;
            m_if_done  = 0;
            m_mem_done = 0;
            m_err      = 0;
            if (m_owner == 0) begin
                if (mem_pend) begin
                    m_owner = 1; m_req = 1; m_waited = 0;
                    m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
                end else if (if_pend) begin
                    m_owner = 2; m_req = 1; m_waited = 0;
                    m_we = 0; m_sel = 4'hF; m_addr = if_addr;
                end
            end else if (bus_ack) begin
                if (m_owner == 1) begin m_mem_rdata = bus_rdata; m_mem_done = 1; end
                else begin m_if_rdata = bus_rdata; m_if_done = 1; end
                m_owner = 0; m_req = 0;
            end else begin
`ifdef ARB_TIMEOUT_EN
                m_waited++;
                if (m_waited == MAX_WAIT) begin
                    if (m_owner == 1) begin m_mem_rdata = 32'h0; m_mem_done = 1; end
                    else begin m_if_rdata = 32'h0; m_if_done = 1; end
                    m_err = 1; m_owner = 0; m_req = 0;
                end
`endif
            end
        end
        m_started = 1'b1;
    end

    // ---------------- per-cycle compare + event counters ----------------
    int   req_rises = 0, if_pulses = 0, mem_pulses = 0;
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        if (m_started) begin
            chk("bus_req", {31'h0, bus_req}, {31'h0, m_req});
            chk("bus_we", {31'h0, bus_we}, {31'h0, m_we});
            chk("bus_sel", {28'h0, bus_sel}, {28'h0, m_sel});
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_wdata", bus_wdata, m_wdata);
            chk("if_done", {31'h0, if_done}, {31'h0, m_if_done});
            chk("mem_done", {31'h0, mem_done}, {31'h0, m_mem_done});
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("mem_rdata", mem_rdata, m_mem_rdata);
            chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
            chk("stallreq_if", {31'h0, stallreq_if}, {31'h0, if_req & ~m_if_done});
            chk("stallreq_mem", {31'h0, stallreq_mem}, {31'h0, mem_req & ~m_mem_done});
            if (bus_req && !prev_req) req_rises++;
            if (if_done) if_pulses++;
            if (mem_done) mem_pulses++;
            prev_req = bus_req;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the chosen done pulse; returns cycles since call.
    task automatic wait_done(input bit is_mem, input int limit, output int cyc);
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            step();
            cyc++;
            seen = is_mem ? mem_done : if_done;
        end
        chk("wait_bound", {31'h0, seen}, 32'h1);
    endtask

    int cyc, rises0, ifp0;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 32'h0;
        mem_req = 0; mem_we = 0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_rdata = 32'h0; ack_en = 1'b1; wait_cfg = 0; ack_force = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_bus_req", {31'h0, bus_req}, 32'h0);
        chk("reset_bus_sel", {28'h0, bus_sel}, 32'h0);
        chk("reset_if_rdata", if_rdata, 32'h0);
        step();

        // 1: fetch, ack in first bus cycle
        rises0 = req_rises;
        if_addr = 32'h1C000000; bus_rdata = 32'h02C00000; if_req = 1'b1;
        wait_done(1'b0, 20, cyc);
        chk("fetch_latency", cyc, 32'd2);
        chk("fetch_rdata", if_rdata, 32'h02C00000);
        chk("fetch_stall_done", {31'h0, stallreq_if}, 32'h0);
        step();
        if_req = 1'b0;
        step(); step();
        chk("fetch_one_txn", req_rises - rises0, 32'd1);

        // 2: store, 3 wait cycles
        wait_cfg = 3; bus_rdata = 32'h11223344;
        step();
        ifp0 = if_pulses;
        mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h80; mem_wdata = 32'hDEADBEEF; mem_req = 1'b1;
        wait_done(1'b1, 30, cyc);
        chk("store_latency", cyc, 32'd5);
        chk("store_rdata", mem_rdata, 32'h11223344);
        step();
        mem_req = 1'b0;
        step();
        chk("store_no_if", if_pulses - ifp0, 32'd0);

        // 3: simultaneous requests, data first, one-cycle gap, then fetch
        wait_cfg = 1;
        step();
        mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200; mem_wdata = 32'h0;
        if_addr = 32'h1C000004; bus_rdata = 32'hA5A5A5A5;
        mem_req = 1'b1; if_req = 1'b1;
        wait_done(1'b1, 30, cyc);
        chk("both_mem_latency", cyc, 32'd3);
        chk("both_mem_rdata", mem_rdata, 32'hA5A5A5A5);
        chk("both_if_stalled", {31'h0, stallreq_if}, 32'h1);
        mem_req = 1'b0; bus_rdata = 32'h5A5A5A5A;
        wait_done(1'b0, 30, cyc);
        chk("both_if_latency", cyc, 32'd3);
        chk("both_if_rdata", if_rdata, 32'h5A5A5A5A);
        step();
        if_req = 1'b0;
        step();

        // 4: reset during BUSY_I, late ack ignored, then normal fetch
        ack_en = 1'b0; wait_cfg = 0;
        step();
        ifp0 = if_pulses;
        if_addr = 32'h1C000008; bus_rdata = 32'hCAFEF00D; if_req = 1'b1;
        step(); step(); step();
        chk("rst_busy_before", {31'h0, bus_req}, 32'h1);
        rst = 1'b1; if_req = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        step();
        ack_force = 1'b1;
        step();
        ack_force = 1'b0;
        step(); step();
        chk("rst_no_done", if_pulses - ifp0, 32'd0);
        ack_en = 1'b1;
        step();
        if_addr = 32'h1C00000C; bus_rdata = 32'h13579BDF; if_req = 1'b1;
        wait_done(1'b0, 20, cyc);
        chk("post_rst_latency", cyc, 32'd2);
        chk("post_rst_rdata", if_rdata, 32'h13579BDF);
        step();
        if_req = 1'b0;
        step();

        // 5: load held through done, dropped next cycle: exactly one grant
        rises0 = req_rises;
        mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h44; bus_rdata = 32'h0BADC0DE; mem_req = 1'b1;
        wait_done(1'b1, 20, cyc);
        chk("hold_latency", cyc, 32'd2);
        step();
        mem_req = 1'b0;
        step(); step(); step();
        chk("hold_one_txn", req_rises - rises0, 32'd1);
        chk("hold_rdata", mem_rdata, 32'h0BADC0DE);

`ifdef ARB_TIMEOUT_EN
        // 6: load never acked -> timeout abort, then a normal request
        ack_en = 1'b0;
        step();
        mem_addr = 32'h48; mem_req = 1'b1;
        wait_done(1'b1, 40, cyc);
        chk("timeout_latency", cyc, MAX_WAIT + 1);
        chk("timeout_err", {31'h0, bus_err}, 32'h1);
        chk("timeout_rdata", mem_rdata, 32'h0);
        step();
        mem_req = 1'b0; ack_en = 1'b1;
        step();
        if_addr = 32'h1C000010; bus_rdata = 32'h24681357; if_req = 1'b1;
        wait_done(1'b0, 20, cyc);
        chk("after_timeout_rdata", if_rdata, 32'h24681357);
        step();
        if_req = 1'b0;
        step();
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
